// File: rtl/alarm_reg_write_arbiter.sv
// Single write-port owner for the alarm register file: set, disable (read-modify-write) and clear-all.
// Set and error replies take 1 cycle. Disable takes 2 cycles. Clear-all takes N_REGS cycles. Requests wait while busy.
module alarm_reg_write_arbiter #(
  parameter int N_REGS = 7,
  parameter int DATA_W = 13,
  parameter int EN_BIT = 12
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              set_req,
  input  logic [2:0]        set_idx,
  input  logic [DATA_W-1:0] set_data,
  output logic              set_ack,
  input  logic              dis_req,
  input  logic [2:0]        dis_idx,
  output logic              dis_ack,
  input  logic              clr_req,
  output logic              clr_ack,
  output logic              err,
  input  logic [DATA_W-1:0] rd_data,
  output logic [2:0]        STO,
  output logic [DATA_W-1:0] D,
  output logic              Enable,
  output logic              busy
);

  localparam int IDX_W = 3;
  localparam logic [IDX_W:0]    N_REGS_W = (IDX_W+1)'(N_REGS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REGS - 1);
  localparam logic [DATA_W-1:0] EN_MASK  = DATA_W'(1) << EN_BIT;

  typedef enum logic [1:0] {IDLE, READ, WRITE, CLR} state_t;

  state_t              state_q, state_d;
  logic                favor_dis_q, favor_dis_d;
  logic [IDX_W-1:0]    sto_q, sto_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                enable_q, enable_d;
  logic                set_ack_q, set_ack_d;
  logic                dis_ack_q, dis_ack_d;
  logic                clr_ack_q, clr_ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                set_idx_ok, dis_idx_ok, set_wins;

  assign set_idx_ok = ({1'b0, set_idx} < N_REGS_W);
  assign dis_idx_ok = ({1'b0, dis_idx} < N_REGS_W);
  // Round-robin between set and disable; clear-all bypasses it and leaves the pointer alone.
  assign set_wins   = set_req && (!dis_req || !favor_dis_q);

  always_comb begin
    state_d     = state_q;
    favor_dis_d = favor_dis_q;
    sto_d       = sto_q;
    d_d         = d_q;
    enable_d    = 1'b0;
    set_ack_d   = 1'b0;
    dis_ack_d   = 1'b0;
    clr_ack_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        sto_d = '0;
        d_d   = '0;
        if (clr_req) begin
          state_d   = CLR;
          enable_d  = 1'b1;
          clr_ack_d = (LAST_IDX == '0);
        end else if (set_wins) begin
          favor_dis_d = 1'b1;
          state_d     = WRITE;
          set_ack_d   = 1'b1;
          if (set_idx_ok) begin
            sto_d    = set_idx;
            d_d      = set_data;
            enable_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (dis_req) begin
          favor_dis_d = 1'b0;
          if (dis_idx_ok) begin
            state_d = READ;
            sto_d   = dis_idx;
          end else begin
            state_d   = WRITE;
            dis_ack_d = 1'b1;
            err_d     = 1'b1;
          end
        end
      end

      // STO already points at the target, so rd_data is the current word.
      READ: begin
        state_d   = WRITE;
        d_d       = rd_data & ~EN_MASK;
        enable_d  = 1'b1;
        dis_ack_d = 1'b1;
      end

      WRITE: begin
        state_d = IDLE;
        sto_d   = '0;
        d_d     = '0;
      end

      CLR: begin
        d_d = '0;
        if (sto_q == LAST_IDX) begin
          state_d = IDLE;
          sto_d   = '0;
        end else begin
          sto_d     = sto_q + 1'b1;
          enable_d  = 1'b1;
          clr_ack_d = (sto_q + 1'b1 == LAST_IDX);
        end
      end

      default: begin
        state_d = IDLE;
        sto_d   = '0;
        d_d     = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q     <= IDLE;
      favor_dis_q <= 1'b0;
      sto_q       <= '0;
      d_q         <= '0;
      enable_q    <= 1'b0;
      set_ack_q   <= 1'b0;
      dis_ack_q   <= 1'b0;
      clr_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      favor_dis_q <= favor_dis_d;
      sto_q       <= sto_d;
      d_q         <= d_d;
      enable_q    <= enable_d;
      set_ack_q   <= set_ack_d;
      dis_ack_q   <= dis_ack_d;
      clr_ack_q   <= clr_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign STO     = sto_q;
  assign D       = d_q;
  assign Enable  = enable_q;
  assign set_ack = set_ack_q;
  assign dis_ack = dis_ack_q;
  assign clr_ack = clr_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

  a_enable_in_write: assert property (@(posedge Clock) disable iff (Clear)
    enable_q |-> (state_q == WRITE || state_q == CLR));
  a_one_ack: assert property (@(posedge Clock) disable iff (Clear)
    $onehot0({set_ack_q, dis_ack_q, clr_ack_q}));

endmodule

// File: tb/tb_alarm_reg_write_arbiter.sv
// Directed bench for alarm_reg_write_arbiter with a behavioural 8-entry register file behind STO/D/Enable.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_alarm_reg_write_arbiter;

  logic        Clock;
  logic        Clear;
  logic        set_req, dis_req, clr_req;
  logic [2:0]  set_idx, dis_idx;
  logic [12:0] set_data;
  logic        set_ack, dis_ack, clr_ack, err;
  logic [12:0] rd_data;
  logic [2:0]  STO;
  logic [12:0] D;
  logic        Enable, busy;

  logic [12:0] model [0:7];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [12:0] pre_dat;

  int n_chk;
  int n_fail;

  alarm_reg_write_arbiter dut (
    .Clock(Clock), .Clear(Clear),
    .set_req(set_req), .set_idx(set_idx), .set_data(set_data), .set_ack(set_ack),
    .dis_req(dis_req), .dis_idx(dis_idx), .dis_ack(dis_ack),
    .clr_req(clr_req), .clr_ack(clr_ack), .err(err),
    .rd_data(rd_data), .STO(STO), .D(D), .Enable(Enable), .busy(busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (pre_we) model[pre_idx] <= pre_dat;
    else if (Enable) model[STO] <= D;
  end

  assign rd_data = (STO < 3'd7) ? model[STO] : 13'h0;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [12:0] dat);
    pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    step(); step();
    n_chk++; if ({STO, D, Enable} !== 17'h0) begin n_fail++; $display("FAIL reset_port: STO=%h D=%h En=%b want 0", STO, D, Enable); end
    n_chk++; if ({set_ack, dis_ack, clr_ack, err, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {set_ack, dis_ack, clr_ack, err, busy}); end
    Clear = 1'b0;
    step();
    n_chk++; if ({busy, Enable} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: busy/En=%b want 00", {busy, Enable}); end
  endtask

  task automatic test_set();
    set_req = 1'b1; set_idx = 3'd2; set_data = 13'h1ABC;
    step();
    n_chk++; if ({STO, D, Enable, set_ack, err} !== {3'd2, 13'h1ABC, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL set_write: STO=%h D=%h En=%b ack=%b err=%b want 2 1abc 1 1 0", STO, D, Enable, set_ack, err); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL set_busy: got %b want 1", busy); end
    set_req = 1'b0;
    step();
    n_chk++; if (model[2] !== 13'h1ABC) begin n_fail++; $display("FAIL set_reg2: got %h want 1abc", model[2]); end
    n_chk++; if ({busy, Enable, set_ack} !== 3'b000) begin n_fail++; $display("FAIL set_idle: got %b want 000", {busy, Enable, set_ack}); end
  endtask

  task automatic test_disable();
    preload(3'd4, 13'h1FFF);
    dis_req = 1'b1; dis_idx = 3'd4;
    step();
    n_chk++; if ({STO, Enable, dis_ack, busy} !== {3'd4, 1'b0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL dis_read: STO=%h En=%b ack=%b busy=%b want 4 0 0 1", STO, Enable, dis_ack, busy); end
    dis_idx = 3'd1;
    step();
    n_chk++; if ({STO, D, Enable, dis_ack} !== {3'd4, 13'h0FFF, 1'b1, 1'b1}) begin n_fail++; $display("FAIL dis_write: STO=%h D=%h En=%b ack=%b want 4 0fff 1 1", STO, D, Enable, dis_ack); end
    dis_req = 1'b0;
    step();
    n_chk++; if (model[4] !== 13'h0FFF) begin n_fail++; $display("FAIL dis_reg4: got %h want 0fff", model[4]); end
    n_chk++; if (model[1] !== 13'h0) begin n_fail++; $display("FAIL dis_reg1_untouched: got %h want 0", model[1]); end
  endtask

  task automatic test_round_robin();
    Clear = 1'b1; step(); Clear = 1'b0;
    preload(3'd3, 13'h1234);
    set_req = 1'b1; set_idx = 3'd1; set_data = 13'h0111;
    dis_req = 1'b1; dis_idx = 3'd3;
    step();
    n_chk++; if ({set_ack, dis_ack, STO} !== {1'b1, 1'b0, 3'd1}) begin n_fail++; $display("FAIL rr_first_set: set=%b dis=%b STO=%h want 1 0 1", set_ack, dis_ack, STO); end
    set_idx = 3'd5; set_data = 13'h0555;
    step();
    n_chk++; if ({busy, Enable} !== 2'b00) begin n_fail++; $display("FAIL rr_gap: busy/En=%b want 00", {busy, Enable}); end
    step();
    n_chk++; if ({STO, Enable, set_ack, busy} !== {3'd3, 1'b0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL rr_dis_second: STO=%h En=%b set=%b busy=%b want 3 0 0 1", STO, Enable, set_ack, busy); end
    step();
    n_chk++; if ({D, dis_ack, Enable} !== {13'h0234, 1'b1, 1'b1}) begin n_fail++; $display("FAIL rr_dis_write: D=%h ack=%b En=%b want 0234 1 1", D, dis_ack, Enable); end
    dis_req = 1'b0;
    step();
    step();
    n_chk++; if ({set_ack, STO, D} !== {1'b1, 3'd5, 13'h0555}) begin n_fail++; $display("FAIL rr_set_third: ack=%b STO=%h D=%h want 1 5 0555", set_ack, STO, D); end
    set_req = 1'b0;
    step();
    n_chk++; if ({model[1], model[3], model[5]} !== {13'h0111, 13'h0234, 13'h0555}) begin n_fail++; $display("FAIL rr_regs: r1=%h r3=%h r5=%h want 0111 0234 0555", model[1], model[3], model[5]); end
  endtask

  task automatic test_clear_all();
    clr_req = 1'b1;
    set_req = 1'b1; set_idx = 3'd6; set_data = 13'h0666;
    for (int i = 0; i < 7; i++) begin
      step();
      n_chk++; if ({STO, D, Enable, clr_ack, set_ack} !== {3'(i), 13'h0, 1'b1, (i == 6), 1'b0}) begin n_fail++; $display("FAIL clr_cycle%0d: STO=%h D=%h En=%b clr=%b set=%b", i, STO, D, Enable, clr_ack, set_ack); end
    end
    clr_req = 1'b0;
    step();
    n_chk++; if ({busy, Enable, clr_ack} !== 3'b000) begin n_fail++; $display("FAIL clr_idle: got %b want 000", {busy, Enable, clr_ack}); end
    for (int i = 0; i < 7; i++) begin
      n_chk++; if (model[i] !== 13'h0) begin n_fail++; $display("FAIL clr_reg%0d: got %h want 0", i, model[i]); end
    end
    step();
    n_chk++; if ({set_ack, STO, D, Enable} !== {1'b1, 3'd6, 13'h0666, 1'b1}) begin n_fail++; $display("FAIL clr_then_set: ack=%b STO=%h D=%h En=%b", set_ack, STO, D, Enable); end
    set_req = 1'b0;
    step();
    n_chk++; if (model[6] !== 13'h0666) begin n_fail++; $display("FAIL clr_set_reg6: got %h want 0666", model[6]); end
  endtask

  task automatic test_invalid_idx();
    set_req = 1'b1; set_idx = 3'd7; set_data = 13'h1FFF;
    step();
    n_chk++; if ({set_ack, err, Enable} !== 3'b110) begin n_fail++; $display("FAIL inv_set: ack/err/En=%b want 110", {set_ack, err, Enable}); end
    set_req = 1'b0;
    step();
    n_chk++; if ({err, busy, Enable} !== 3'b000) begin n_fail++; $display("FAIL inv_set_after: err/busy/En=%b want 000", {err, busy, Enable}); end
    n_chk++; if ({model[0], model[6]} !== {13'h0, 13'h0666}) begin n_fail++; $display("FAIL inv_regs: r0=%h r6=%h want 0 0666", model[0], model[6]); end
    dis_req = 1'b1; dis_idx = 3'd7;
    step();
    n_chk++; if ({dis_ack, err, Enable, busy} !== 4'b1101) begin n_fail++; $display("FAIL inv_dis: ack/err/En/busy=%b want 1101", {dis_ack, err, Enable, busy}); end
    dis_req = 1'b0;
    step();
    n_chk++; if ({busy, Enable, dis_ack} !== 3'b000) begin n_fail++; $display("FAIL inv_dis_noread: busy/En/ack=%b want 000", {busy, Enable, dis_ack}); end
  endtask

  task automatic test_reset_mid_clear();
    preload(3'd4, 13'h0AAA);
    preload(3'd5, 13'h0BBB);
    preload(3'd6, 13'h0CCC);
    clr_req = 1'b1;
    step(); step(); step(); step();
    n_chk++; if ({STO, Enable} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL midclr_sto3: STO=%h En=%b want 3 1", STO, Enable); end
    Clear = 1'b1;
    step();
    n_chk++; if ({STO, D, Enable, clr_ack, busy} !== {3'd0, 13'h0, 1'b0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL midclr_reset: STO=%h D=%h En=%b ack=%b busy=%b", STO, D, Enable, clr_ack, busy); end
    Clear = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if ({Enable, clr_ack} !== 2'b00) begin n_fail++; $display("FAIL midclr_quiet%0d: En/ack=%b want 00", i, {Enable, clr_ack}); end
    end
    n_chk++; if ({model[4], model[5], model[6]} !== {13'h0AAA, 13'h0BBB, 13'h0CCC}) begin n_fail++; $display("FAIL midclr_regs: r4=%h r5=%h r6=%h want 0aaa 0bbb 0ccc", model[4], model[5], model[6]); end
    n_chk++; if (model[3] !== 13'h0) begin n_fail++; $display("FAIL midclr_reg3: got %h want 0", model[3]); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    Clear = 1'b1;
    set_req = 1'b0; set_idx = 3'd0; set_data = 13'h0;
    dis_req = 1'b0; dis_idx = 3'd0;
    clr_req = 1'b0;
    pre_we = 1'b0; pre_idx = 3'd0; pre_dat = 13'h0;
    for (int i = 0; i < 8; i++) model[i] = 13'h0;
    test_reset();
    test_set();
    test_disable();
    test_round_robin();
    test_clear_all();
    test_invalid_idx();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
